hex_display_arbiter: RTL and testbench

- Shares the single 4-digit hex display between two requesters: the processor (memory-mapped write path) and the debug/monitor path (e.g. PC or register probe).
- Latches the granted 16-bit value and drives the display block's value and enable inputs.
- Round-robin arbitration with a minimum dwell time, so neither source can flicker the other off the display.

---
 rtl/hex_display_arbiter_pkg.sv | 29 ++
 rtl/hex_display_arbiter_dwell_counter.sv | 33 +++
 rtl/hex_display_arbiter.sv | 166 ++++++++++++++++
 tb/tb_hex_display_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_arbiter_pkg.sv
// Shared definitions for the hex display arbiter: FSM state encoding,
// owner codes reported on the owner port, and the idle-timer width.
package hex_display_arbiter_pkg;

    // Arbiter state; encoded so that the state value equals the owner code.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        HOLD_CPU = 2'b01,
        HOLD_DBG = 2'b10
    } arb_state_t;

    // Owner codes presented on the owner output.
    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_CPU  = 2'b01;
    localparam logic [1:0] OWNER_DBG  = 2'b10;

    // Width of the inactivity timer used by the optional blanking feature.
    localparam int IDLE_CNT_W = 26;

    // Maps an arbiter state onto the externally visible owner code.
    function automatic logic [1:0] owner_code(input arb_state_t st);
        case (st)
            HOLD_CPU: return OWNER_CPU;
            HOLD_DBG: return OWNER_DBG;
            default:  return OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/hex_display_arbiter_dwell_counter.sv
// Loadable down-counter that saturates at zero and flags when it is there.
// Used for the owner dwell time and, optionally, for the inactivity timer.
// Load has priority over clear, clear has priority over counting.
module hex_display_arbiter_dwell_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_count_en,
    input  logic             i_clear,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    // Count register: load, clear, or decrement toward zero and stay there.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/hex_display_arbiter.sv
// Two-source arbiter for the shared 4-digit hex display.
// The processor and the debug path each request with a level req held until
// its one-cycle ack. A newly granted owner keeps the display for at least
// DWELL_CYCLES cycles; the current owner may refresh its value at any time.
// Contention while free is settled by a round-robin pointer.
// Optional feature macro: HEX_DISPLAY_BLANK_TIMEOUT_EN -- when defined, the
// display blanks (returns to IDLE) after IDLE_TIMEOUT cycles with no accept.
module hex_display_arbiter
    import hex_display_arbiter_pkg::*;
#(
    parameter int DWELL_CYCLES = 1024,
    parameter int IDLE_TIMEOUT = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [15:0] cpu_data,
    output logic        cpu_ack,
    input  logic        dbg_req,
    input  logic [15:0] dbg_data,
    output logic        dbg_ack,
    output logic [15:0] display_value,
    output logic        display_enable,
    output logic [1:0]  owner
);

    localparam int                 DWELL_W    = $clog2(DWELL_CYCLES + 1);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

    // Reject parameter values outside the supported range at elaboration.
    generate
        if ((DWELL_CYCLES < 1) || (DWELL_CYCLES > (1 << 20))) begin : g_bad_dwell
            $error("DWELL_CYCLES must lie in 1 .. 2**20");
        end
        if ((IDLE_TIMEOUT < 1) || (IDLE_TIMEOUT > (1 << IDLE_CNT_W))) begin : g_bad_timeout
            $error("IDLE_TIMEOUT must lie in 1 .. 2**26");
        end
    endgenerate

    // Registered state
    arb_state_t  r_state;
    logic [15:0] r_display_value;
    logic        r_cpu_ack;
    logic        r_dbg_ack;
    logic        r_rr_dbg;        // 1: debug path wins the next contention

    // Next-state and control wires
    arb_state_t  w_state_next;
    logic [15:0] w_value_next;
    logic        w_cpu_ack_next;
    logic        w_dbg_ack_next;
    logic        w_rr_dbg_next;
    logic        w_dwell_load;
    logic        w_accept;
    logic        w_dwell_done;
    logic        w_idle_done;
    logic        w_free;
    logic        w_cpu_ok;
    logic        w_dbg_ok;
    logic        w_grant_cpu;
    logic        w_grant_dbg;

    // Minimum-ownership timer, loaded only when ownership changes hands.
    hex_display_arbiter_dwell_counter #(
        .WIDTH        (DWELL_W)
    ) u_dwell (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_dwell_load),
        .i_load_value (DWELL_LOAD),
        .i_count_en   (1'b1),
        .i_clear      (1'b0),
        .o_done       (w_dwell_done)
    );

`ifdef HEX_DISPLAY_BLANK_TIMEOUT_EN
    // Inactivity timer: restarted by every accept, runs while an owner holds
    // the display, parked at zero while idle. Counting down from
    // IDLE_TIMEOUT-1 gives the same expiry point as counting up to it.
    hex_display_arbiter_dwell_counter #(
        .WIDTH        (IDLE_CNT_W)
    ) u_idle (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_accept),
        .i_load_value (IDLE_CNT_W'(IDLE_TIMEOUT - 1)),
        .i_count_en   (r_state != IDLE),
        .i_clear      (r_state == IDLE),
        .o_done       (w_idle_done)
    );
`else
    assign w_idle_done = 1'b0;
`endif

    // Eligibility: a req just acked is ignored for one cycle; a non-owner
    // may only take the display when the arbiter is free.
    always_comb begin
        w_free   = (r_state == IDLE) || w_dwell_done;
        w_cpu_ok = cpu_req && !r_cpu_ack && (w_free || (r_state == HOLD_CPU));
        w_dbg_ok = dbg_req && !r_dbg_ack && (w_free || (r_state == HOLD_DBG));
    end

    // Grant selection; the pointer only moves on real contention and then
    // points at the loser.
    always_comb begin
        w_grant_cpu   = w_cpu_ok;
        w_grant_dbg   = w_dbg_ok;
        w_rr_dbg_next = r_rr_dbg;
        if (w_cpu_ok && w_dbg_ok) begin
            w_grant_cpu   = !r_rr_dbg;
            w_grant_dbg   = r_rr_dbg;
            w_rr_dbg_next = !r_rr_dbg;
        end
    end

    // FSM next state, latched value and ack pulses.
    always_comb begin
        w_state_next   = r_state;
        w_value_next   = r_display_value;
        w_cpu_ack_next = 1'b0;
        w_dbg_ack_next = 1'b0;
        w_dwell_load   = 1'b0;
        w_accept       = 1'b0;
        if (w_grant_cpu) begin
            w_state_next   = HOLD_CPU;
            w_value_next   = cpu_data;
            w_cpu_ack_next = 1'b1;
            w_dwell_load   = (r_state != HOLD_CPU);
            w_accept       = 1'b1;
        end else if (w_grant_dbg) begin
            w_state_next   = HOLD_DBG;
            w_value_next   = dbg_data;
            w_dbg_ack_next = 1'b1;
            w_dwell_load   = (r_state != HOLD_DBG);
            w_accept       = 1'b1;
        end else if ((r_state != IDLE) && w_idle_done) begin
            // Only reachable with the blanking timer built in; the value is
            // kept so a later re-enable shows the last content.
            w_state_next   = IDLE;
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_display_value <= 16'h0000;
            r_cpu_ack       <= 1'b0;
            r_dbg_ack       <= 1'b0;
            r_rr_dbg        <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_display_value <= w_value_next;
            r_cpu_ack       <= w_cpu_ack_next;
            r_dbg_ack       <= w_dbg_ack_next;
            r_rr_dbg        <= w_rr_dbg_next;
        end
    end

    assign cpu_ack        = r_cpu_ack;
    assign dbg_ack        = r_dbg_ack;
    assign display_value  = r_display_value;
    assign display_enable = (r_state != IDLE);
    assign owner          = owner_code(r_state);

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter (DWELL_CYCLES=4, IDLE_TIMEOUT=8).
// Directed scenarios first, then randomized requesters. The reference model
// tracks ownership with timestamps (cycle of last ownership change and of
// last accept) rather than counters.
module tb_hex_display_arbiter;

    localparam int DWELL   = 4;
    localparam int TIMEOUT = 8;
`ifdef HEX_DISPLAY_BLANK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        cpu_req  = 1'b0;
    logic [15:0] cpu_data = 16'h0000;
    logic        dbg_req  = 1'b0;
    logic [15:0] dbg_data = 16'h0000;
    logic        cpu_ack;
    logic        dbg_ack;
    logic [15:0] display_value;
    logic        display_enable;
    logic [1:0]  owner;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    // Reference model state
    int          m_owner     = 0;   // 0 none, 1 cpu, 2 dbg
    logic [15:0] m_value     = 16'h0000;
    bit          m_cpu_ack   = 1'b0;
    bit          m_dbg_ack   = 1'b0;
    bit          m_rr_dbg    = 1'b0;
    longint      m_grant_cyc = 0;
    longint      m_accept_cyc = 0;

    hex_display_arbiter #(
        .DWELL_CYCLES   (DWELL),
        .IDLE_TIMEOUT   (TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_data       (cpu_data),
        .cpu_ack        (cpu_ack),
        .dbg_req        (dbg_req),
        .dbg_data       (dbg_data),
        .dbg_ack        (dbg_ack),
        .display_value  (display_value),
        .display_enable (display_enable),
        .owner          (owner)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Predict the outcome of the coming rising edge from the current inputs.
    task automatic model_edge();
        bit free;
        bit c_ok;
        bit d_ok;
        int win;
        if (reset) begin
            m_owner   = 0;
            m_value   = 16'h0000;
            m_cpu_ack = 1'b0;
            m_dbg_ack = 1'b0;
            m_rr_dbg  = 1'b0;
        end else begin
            free = (m_owner == 0) || ((cyc - m_grant_cyc) >= DWELL);
            c_ok = cpu_req && !m_cpu_ack && (free || m_owner == 1);
            d_ok = dbg_req && !m_dbg_ack && (free || m_owner == 2);
            win  = 0;
            if (c_ok && d_ok) begin
                win      = m_rr_dbg ? 2 : 1;
                m_rr_dbg = (win == 1);
            end else if (c_ok) begin
                win = 1;
            end else if (d_ok) begin
                win = 2;
            end
            m_cpu_ack = (win == 1);
            m_dbg_ack = (win == 2);
            if (win != 0) begin
                if (win != m_owner) m_grant_cyc = cyc;
                m_owner      = win;
                m_value      = (win == 1) ? cpu_data : dbg_data;
                m_accept_cyc = cyc;
            end else if (TO_EN && m_owner != 0 && (cyc - m_accept_cyc) >= TIMEOUT) begin
                m_owner = 0;
            end
        end
        cyc++;
    endtask

    // One clock: model prediction, edge, then compare all outputs.
    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        check_eq("cpu_ack", 32'(cpu_ack), 32'(m_cpu_ack));
        check_eq("dbg_ack", 32'(dbg_ack), 32'(m_dbg_ack));
        check_eq("display_value", 32'(display_value), 32'(m_value));
        check_eq("display_enable", 32'(display_enable), 32'(m_owner != 0));
        check_eq("owner", 32'(owner), 32'(m_owner));
        if (cpu_ack) $display("cycle %0d: cpu accept, value %04h", cyc, display_value);
        if (dbg_ack) $display("cycle %0d: dbg accept, value %04h", cyc, display_value);
    endtask

    // Protocol-abiding random requester behaviour.
    task automatic drive_random();
        reset = ($urandom_range(0, 299) == 0);
        if (cpu_req) begin
            if (cpu_ack) begin
                if ($urandom_range(0, 3) != 0) cpu_req = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                cpu_req = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            cpu_req  = 1'b1;
            cpu_data = 16'($urandom);
        end
        if (dbg_req) begin
            if (dbg_ack) begin
                if ($urandom_range(0, 3) != 0) dbg_req = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                dbg_req = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            dbg_req  = 1'b1;
            dbg_data = 16'($urandom);
        end
    endtask

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
        $fatal(1, "time limit");
    end

    initial begin
        // Reset for two cycles
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_value", 32'(display_value), 32'h0);
        check_eq("rst_enable", 32'(display_enable), 32'h0);
        check_eq("rst_owner", 32'(owner), 32'h0);
        reset = 1'b0;

        // Single accept
        cpu_req = 1'b1; cpu_data = 16'h1234;
        tick();
        check_eq("single_ack", 32'(cpu_ack), 32'h1);
        check_eq("single_value", 32'(display_value), 32'h1234);
        check_eq("single_owner", 32'(owner), 32'h1);

        // Dwell stall then switch to debug
        cpu_req = 1'b0;
        dbg_req = 1'b1; dbg_data = 16'hBEEF;
        tick();
        check_eq("single_ack_low", 32'(cpu_ack), 32'h0);
        check_eq("stall_1", 32'(dbg_ack), 32'h0);
        tick();
        check_eq("stall_2", 32'(dbg_ack), 32'h0);
        tick();
        check_eq("stall_3", 32'(dbg_ack), 32'h0);
        tick();
        check_eq("switch_ack", 32'(dbg_ack), 32'h1);
        check_eq("switch_value", 32'(display_value), 32'hBEEF);
        check_eq("switch_owner", 32'(owner), 32'h2);
        dbg_req = 1'b0;

        // Refresh during dwell does not reload the dwell timer
        tick(); tick(); tick();
        cpu_req = 1'b1; cpu_data = 16'h5555;
        tick();
        check_eq("regrant_owner", 32'(owner), 32'h1);
        cpu_req = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_data = 16'h0001;
        dbg_req = 1'b1; dbg_data = 16'hCAFE;
        tick();
        check_eq("refresh_ack", 32'(cpu_ack), 32'h1);
        check_eq("refresh_value", 32'(display_value), 32'h0001);
        check_eq("refresh_dbg_stall", 32'(dbg_ack), 32'h0);
        cpu_req = 1'b0;
        tick();
        check_eq("refresh_dbg_stall2", 32'(dbg_ack), 32'h0);
        tick();
        check_eq("refresh_dbg_grant", 32'(dbg_ack), 32'h1);
        check_eq("refresh_dbg_value", 32'(display_value), 32'hCAFE);
        dbg_req = 1'b0;

        // Round-robin from IDLE after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_data = 16'h1111;
        dbg_req = 1'b1; dbg_data = 16'h2222;
        tick();
        check_eq("rr_first_cpu", 32'(cpu_ack), 32'h1);
        check_eq("rr_first_value", 32'(display_value), 32'h1111);
        cpu_req = 1'b0; dbg_req = 1'b0;
        tick(); tick(); tick(); tick();
        cpu_req = 1'b1; cpu_data = 16'h3131;
        dbg_req = 1'b1; dbg_data = 16'h4242;
        tick();
        check_eq("rr_second_dbg", 32'(dbg_ack), 32'h1);
        check_eq("rr_second_cpu", 32'(cpu_ack), 32'h0);
        check_eq("rr_second_owner", 32'(owner), 32'h2);
        cpu_req = 1'b0; dbg_req = 1'b0;

        // Reset mid-hold with a debug request pending
        tick(); tick(); tick();
        cpu_req = 1'b1; cpu_data = 16'h3333;
        tick();
        cpu_req = 1'b0;
        dbg_req = 1'b1; dbg_data = 16'h4444;
        tick();
        reset = 1'b1;
        tick();
        check_eq("midrst_dbg_ack", 32'(dbg_ack), 32'h0);
        check_eq("midrst_value", 32'(display_value), 32'h0);
        check_eq("midrst_enable", 32'(display_enable), 32'h0);
        check_eq("midrst_owner", 32'(owner), 32'h0);
        reset = 1'b0;
        dbg_req = 1'b0;
        tick();

`ifdef HEX_DISPLAY_BLANK_TIMEOUT_EN
        // Blanking after inactivity
        cpu_req = 1'b1; cpu_data = 16'h7777;
        tick();
        cpu_req = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            check_eq("to_still_on", 32'(display_enable), 32'h1);
        end
        tick();
        check_eq("to_blank_enable", 32'(display_enable), 32'h0);
        check_eq("to_blank_owner", 32'(owner), 32'h0);
        check_eq("to_keep_value", 32'(display_value), 32'h7777);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
